div_scheduler: RTL and testbench

DIV_SCHEDULER -- requirements
Module: div_scheduler

---
 rtl/div_scheduler.sv | 158 +++++++++++++++
 tb/tb_div_scheduler.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_scheduler.sv
// div_scheduler: round-robin arbiter sharing one external divider among four
// requesters, one operation in flight, with divide-by-zero and timeout errors.
module div_scheduler #(
    parameter int TIMEOUT = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_valid,
    input  logic [127:0] req_a,
    input  logic [127:0] req_b,
    output logic [3:0]   req_ready,
    output logic         div_in_en,
    output logic [31:0]  div_a,
    output logic [31:0]  div_b,
    input  logic         div_out_en,
    input  logic [31:0]  div_q,
    input  logic [31:0]  div_r,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [1:0]   rsp_id,
    output logic [31:0]  rsp_q,
    output logic [31:0]  rsp_r,
    output logic         rsp_error,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e        state_q;
    logic [1:0]    last_grant_q;
    logic [CW-1:0] cnt_q;
    logic          div_in_en_q;
    logic [31:0]   div_a_q;
    logic [31:0]   div_b_q;
    logic          rsp_valid_q;
    logic          rsp_error_q;
    logic [1:0]    rsp_id_q;
    logic [31:0]   rsp_quo_q;
    logic [31:0]   rsp_rem_q;

    logic          grant_found;
    logic [1:0]    grant_idx;
    logic [1:0]    scan_idx;
    logic [31:0]   grant_a;
    logic [31:0]   grant_b;

    // Scan upward from the requester after the last grant, wrapping, so the
    // most recently served requester has the lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        scan_idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = last_grant_q + 2'(k);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign grant_a = req_a[{grant_idx, 5'd0} +: 32];
    assign grant_b = req_b[{grant_idx, 5'd0} +: 32];

    // Handshakes: a request transfers on a clock edge where req_valid[n] and
    // req_ready[n] are both high; a response transfers on an edge where
    // rsp_valid and rsp_ready are both high. Valid never waits on ready.
    assign req_ready = (state_q == IDLE && grant_found) ? (4'b0001 << grant_idx) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 2'd3;
            cnt_q        <= '0;
            div_in_en_q  <= 1'b0;
            div_a_q      <= 32'd0;
            div_b_q      <= 32'd0;
            rsp_valid_q  <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_id_q     <= 2'd0;
            rsp_quo_q    <= 32'd0;
            rsp_rem_q    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        last_grant_q <= grant_idx;
                        rsp_id_q     <= grant_idx;
                        if (grant_b == 32'd0) begin
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_quo_q   <= 32'd0;
                            rsp_rem_q   <= 32'd0;
                            state_q     <= RESP;
                        end else begin
                            div_a_q     <= grant_a;
                            div_b_q     <= grant_b;
                            div_in_en_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    div_in_en_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    // A completion arriving in the timeout cycle still counts.
                    if (div_out_en) begin
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b0;
                        rsp_quo_q   <= div_q;
                        rsp_rem_q   <= div_r;
                        div_a_q     <= 32'd0;
                        div_b_q     <= 32'd0;
                        state_q     <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        rsp_quo_q   <= 32'd0;
                        rsp_rem_q   <= 32'd0;
                        div_a_q     <= 32'd0;
                        div_b_q     <= 32'd0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_in_en = div_in_en_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = rsp_quo_q;
    assign rsp_r     = rsp_rem_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: table-driven single operations, directed corner
// sequences, and randomized traffic against a transaction-level model.
module tb_div_scheduler;

    localparam int TIMEOUT = 40;
    localparam int RW = 67;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [31:0]  a_arr [4];
    logic [31:0]  b_arr [4];
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic         div_in_en;
    logic [31:0]  div_a;
    logic [31:0]  div_b;
    logic         div_out_en;
    logic [31:0]  div_q;
    logic [31:0]  div_r;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_q;
    logic [31:0]  rsp_r;
    logic         rsp_error;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    int div_pulses = 0;
    int hold_errs = 0;
    int rst_cnt = 0;
    int div_lat = 3;
    bit div_hang = 1'b0;
    bit rand_lat = 1'b0;

    logic [RW-1:0] exp_q [$];

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        err;
        int          lat;
    } vec_t;
    vec_t vecs [9];

    assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign req_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

    div_scheduler #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .div_in_en(div_in_en), .div_a(div_a), .div_b(div_b),
        .div_out_en(div_out_en), .div_q(div_q), .div_r(div_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_error(rsp_error),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Divider model: fixed or random latency, or never answers when hung.
    initial begin : divider_model
        logic [31:0] ma;
        logic [31:0] mb;
        int lat;
        int rc0;
        div_out_en = 1'b0;
        div_q = 32'd0;
        div_r = 32'd0;
        forever begin
            @(negedge clk);
            if (div_in_en === 1'b1) begin
                div_pulses++;
                ma = div_a;
                mb = div_b;
                rc0 = rst_cnt;
                lat = rand_lat ? int'($urandom_range(1, 20)) : div_lat;
                if (!div_hang) begin
                    repeat (lat) @(negedge clk);
                    if (rst_cnt == rc0 && (div_a !== ma || div_b !== mb)) hold_errs++;
                    div_out_en = 1'b1;
                    div_q = (mb != 0) ? ma / mb : 32'hFFFF_FFFF;
                    div_r = (mb != 0) ? ma % mb : ma;
                    @(negedge clk);
                    div_out_en = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == 4'b0000 && n < 100);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 200);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_req_ready"}, 96'(req_ready), 96'(0));
        chk({nm, "_div_in_en"}, 96'(div_in_en), 96'(0));
        chk({nm, "_div_a"},     96'(div_a), 96'(0));
        chk({nm, "_div_b"},     96'(div_b), 96'(0));
        chk({nm, "_rsp_valid"}, 96'(rsp_valid), 96'(0));
        chk({nm, "_rsp_error"}, 96'(rsp_error), 96'(0));
        chk({nm, "_rsp_id"},    96'(rsp_id), 96'(0));
        chk({nm, "_rsp_q"},     96'(rsp_q), 96'(0));
        chk({nm, "_rsp_r"},     96'(rsp_r), 96'(0));
        chk({nm, "_state"},     96'(dbg_state), 96'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 4'b0000;
        rst = 1'b1;
        rst_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One request from a lone requester, held until granted, then checked.
    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic ee,
                          input int elat, input string nm);
        int n;
        int p0;
        step();
        a_arr[id] = a;
        b_arr[id] = b;
        req_valid[id] = 1'b1;
        rsp_ready = 1'b1;
        p0 = div_pulses;
        wait_grant(n);
        chk({nm, "_grant"}, 96'(req_ready), 96'(4'b0001 << id));
        step();
        req_valid[id] = 1'b0;
        wait_rsp(n);
        chk({nm, "_latency"}, 96'(n), 96'(elat));
        chk({nm, "_id"}, 96'(rsp_id), 96'(id));
        chk({nm, "_q"}, 96'(rsp_q), 96'(eq));
        chk({nm, "_r"}, 96'(rsp_r), 96'(er));
        chk({nm, "_err"}, 96'(rsp_error), 96'(ee));
        chk({nm, "_pulses"}, 96'(div_pulses - p0), 96'((b != 0) ? 1 : 0));
        step();
    endtask

    // Randomized traffic: round-robin over whatever is being requested,
    // one outstanding operation, responses in grant order.
    task automatic random_phase(input int ncyc);
        int model_last;
        bit busy;
        int busy_cyc;
        int gi;
        int j;
        bit quiet;
        logic [31:0] ga;
        logic [31:0] gb;
        logic [31:0] tmp;
        logic [RW-1:0] e;
        model_last = 3;
        busy = 1'b0;
        busy_cyc = 0;
        for (int c = 0; c < ncyc; c++) begin
            quiet = (c >= ncyc - 150);
            @(negedge clk);
            gi = -1;
            if (!busy) begin
                for (int k = 1; k <= 4; k++) begin
                    j = (model_last + k) % 4;
                    if (gi < 0 && req_valid[j]) gi = j;
                end
            end
            chk("rand_grant", 96'(req_ready), 96'((gi >= 0) ? (4'b0001 << gi) : 4'b0000));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_spurious_rsp", 96'(exp_q.size()), 96'(1));
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_rsp", 96'({rsp_id, rsp_error, rsp_q, rsp_r}), 96'(e));
                end
                busy = 1'b0;
                busy_cyc = 0;
            end
            if (gi >= 0) begin
                ga = a_arr[gi];
                gb = b_arr[gi];
                exp_q.push_back({2'(gi), gb == 0, (gb == 0) ? 32'd0 : ga / gb,
                                 (gb == 0) ? 32'd0 : ga % gb});
                busy = 1'b1;
                model_last = gi;
            end
            if (busy) busy_cyc++;
            if (busy_cyc > 200) begin
                chk("rand_rsp_timeout", 96'(busy_cyc), 96'(0));
                busy = 1'b0;
                busy_cyc = 0;
            end
            step();
            for (int n = 0; n < 4; n++) begin
                if (gi == n) begin
                    req_valid[n] = 1'b0;
                end else if (req_valid[n]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[n] = 1'b0;
                end else if (!quiet && $urandom_range(0, 3) == 0) begin
                    a_arr[n] = $urandom;
                    tmp = $urandom >> $urandom_range(0, 31);
                    b_arr[n] = ($urandom_range(0, 4) == 0) ? 32'd0 : ((tmp == 0) ? 32'd1 : tmp);
                    req_valid[n] = 1'b1;
                end
            end
            rsp_ready = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        chk("rand_drain", 96'(exp_q.size()), 96'(0));
        req_valid = 4'b0000;
    endtask

    initial begin : main
        int n;
        rst = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = 32'd0;
            b_arr[i] = 32'd0;
        end

        vecs[0] = '{0, 32'd100,        32'd7,          32'd14,         32'd2,   1'b0, 35};
        vecs[1] = '{2, 32'd5,          32'd0,          32'd0,          32'd0,   1'b1, 3};
        vecs[2] = '{1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,   1'b0, 1};
        vecs[3] = '{3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,   1'b0, 7};
        vecs[4] = '{2, 32'd3,          32'd10,         32'd0,          32'd3,   1'b0, 2};
        vecs[5] = '{1, 32'd123456789,  32'd1000,       32'd123456,     32'd789, 1'b0, 12};
        vecs[6] = '{0, 32'h8000_0000,  32'd2,          32'h4000_0000,  32'd0,   1'b0, TIMEOUT + 1};
        vecs[7] = '{3, 32'd0,          32'd0,          32'd0,          32'd0,   1'b1, 3};
        vecs[8] = '{0, 32'd0,          32'd9,          32'd0,          32'd0,   1'b0, TIMEOUT};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_req", 96'(req_ready), 96'(0));
        chk("idle_state", 96'(dbg_state), 96'(0));

        for (int i = 0; i < 9; i++) begin
            div_lat = vecs[i].lat;
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].err,
                   (vecs[i].b == 0) ? 1 : vecs[i].lat + 2, $sformatf("vec%0d", i));
        end

        // Fairness with every requester asserting from reset
        do_reset();
        div_lat = 2;
        step();
        for (int k = 0; k < 4; k++) begin
            a_arr[k] = 32'(100 + k);
            b_arr[k] = 32'(k + 3);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_grant(n);
            chk($sformatf("rr_grant%0d", i), 96'(req_ready), 96'(4'b0001 << (i % 4)));
            wait_rsp(n);
            chk($sformatf("rr_id%0d", i), 96'(rsp_id), 96'(i % 4));
            chk($sformatf("rr_q%0d", i), 96'(rsp_q), 96'((100 + i % 4) / (i % 4 + 3)));
        end
        step();
        req_valid = 4'b0000;

        // Divider never answers, then a normal operation
        div_hang = 1'b1;
        run_op(1, 32'd50, 32'd3, 32'd0, 32'd0, 1'b1, TIMEOUT + 3, "timeout");
        div_hang = 1'b0;
        div_lat = 4;
        run_op(3, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 6, "after_timeout");

        // Backpressure on the response with two requesters waiting
        div_lat = 3;
        step();
        a_arr[0] = 32'd60;
        b_arr[0] = 32'd7;
        a_arr[1] = 32'd61;
        b_arr[1] = 32'd0;
        req_valid = 4'b0011;
        rsp_ready = 1'b0;
        wait_grant(n);
        chk("bp_grant0", 96'(req_ready), 96'(4'b0001));
        step();
        req_valid[0] = 1'b0;
        wait_rsp(n);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", 96'({rsp_valid, rsp_id, rsp_error, rsp_q, rsp_r}),
                96'({1'b1, 2'd0, 1'b0, 32'd8, 32'd4}));
            chk("bp_no_grant", 96'(req_ready), 96'(0));
            @(negedge clk);
        end
        step();
        rsp_ready = 1'b1;
        wait_grant(n);
        chk("bp_grant1", 96'(req_ready), 96'(4'b0010));
        step();
        req_valid = 4'b0000;
        wait_rsp(n);
        chk("bp_rsp1", 96'({rsp_id, rsp_error, rsp_q, rsp_r}), 96'({2'd1, 1'b1, 32'd0, 32'd0}));
        step();

        // Reset while waiting on the divider; its late completion must be ignored
        div_lat = 10;
        step();
        a_arr[2] = 32'd77;
        b_arr[2] = 32'd5;
        req_valid = 4'b0100;
        wait_grant(n);
        chk("rw_grant", 96'(req_ready), 96'(4'b0100));
        step();
        req_valid = 4'b0000;
        n = 0;
        do begin @(negedge clk); n++; end while (!div_in_en && n < 10);
        chk("rw_issue", 96'(div_in_en), 96'(1));
        repeat (5) @(negedge clk);
        rst = 1'b1;
        rst_cnt++;
        #1;
        check_all_zero("rw_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rw_quiet", 96'({rsp_valid, div_in_en, dbg_state}), 96'(0));
        end
        step();
        for (int k = 0; k < 4; k++) begin
            a_arr[k] = 32'd90;
            b_arr[k] = 32'd9;
        end
        req_valid = 4'b1111;
        wait_grant(n);
        chk("rw_next_grant", 96'(req_ready), 96'(4'b0001));
        step();
        req_valid = 4'b0000;
        wait_rsp(n);
        chk("rw_next_rsp", 96'({rsp_id, rsp_error, rsp_q, rsp_r}), 96'({2'd0, 1'b0, 32'd10, 32'd0}));
        step();

        // Random traffic
        do_reset();
        rand_lat = 1'b1;
        random_phase(1500);
        rand_lat = 1'b0;

        chk("div_operand_hold", 96'(hold_errs), 96'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
